// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply result path: entry count, index width
// and the unloader's state encoding.
package matmul_pkg;

  localparam int MAT_ENTRIES    = 4;
  localparam int IDX_W          = 2;
  localparam int DEFAULT_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_RELEASE  = 2'd2,
    ST_WAIT_LOW = 2'd3
  } unl_state_e;

endpackage

// File: rtl/result_buffer.sv
// Four-entry result register file: all entries are loaded together on cap_en,
// one entry is read out by index.
module result_buffer
  import matmul_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          cap_en,
  input  logic [MAT_ENTRIES*DATA_W-1:0] cap_flat,
  input  logic [IDX_W-1:0]              rd_idx,
  output logic [DATA_W-1:0]             rd_data
);

  logic [DATA_W-1:0] mem_q [MAT_ENTRIES];
  logic [DATA_W-1:0] mem_d [MAT_ENTRIES];

  always_comb begin
    for (int i = 0; i < MAT_ENTRIES; i++) begin
      mem_d[i] = mem_q[i];
      if (cap_en) begin
        mem_d[i] = cap_flat[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MAT_ENTRIES; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MAT_ENTRIES; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/matrix_result_unloader.sv
// Drains the 2x2 result matrix over valid/ready in row-major order after each rising
// edge of done, then pulses release_pulse so the controller can leave its Store state.
module matrix_result_unloader
  import matmul_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          done,
  input  logic [MAT_ENTRIES*DATA_W-1:0] c_flat,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [DATA_W-1:0]             out_data,
  output logic [IDX_W-1:0]              out_index,
  output logic                          out_last,
  // "release" is a reserved word in SystemVerilog, hence the suffix.
  output logic                          release_pulse,
  output logic                          busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAT_ENTRIES - 1);

  unl_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic             cap_en;
  logic [DATA_W-1:0] rd_data;

  result_buffer #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clock    (clock),
    .reset    (reset),
    .cap_en   (cap_en),
    .cap_flat (c_flat),
    .rd_idx   (idx_q),
    .rd_data  (rd_data)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = done;
    cap_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (done && !done_q) begin
          cap_en  = 1'b1;
          idx_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_RELEASE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_RELEASE: begin
        state_d = ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        if (!done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // done_q resets high so a done level held across reset is not seen as a new edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      done_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign out_valid     = (state_q == ST_SEND);
  assign out_data      = out_valid ? rd_data : '0;
  assign out_index     = idx_q;
  assign out_last      = out_valid && (idx_q == LAST_IDX);
  assign release_pulse = (state_q == ST_RELEASE);
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_matrix_result_unloader.sv
// Bench for matrix_result_unloader: directed scenarios plus a randomized run, checked
// against a queue-based model of the drain/release protocol.
module tb_matrix_result_unloader;

  logic        clock;
  logic        reset;
  logic        done;
  logic [63:0] c_flat;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic [1:0]  out_index;
  logic        out_last;
  logic        release_pulse;
  logic        busy;

  matrix_result_unloader #(.DATA_W(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .done          (done),
    .c_flat        (c_flat),
    .out_ready     (out_ready),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_index     (out_index),
    .out_last      (out_last),
    .release_pulse (release_pulse),
    .busy          (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [15:0] data;
    logic [1:0]  idx;
  } ent_t;

  ent_t exp_q[$];
  logic rel_exp;
  int   cool;
  logic m_prev_done;
  int   hs_count;
  int   rel_count;
  int   n_checks;
  int   n_errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    rel_exp     = 1'b0;
    cool        = 0;
    m_prev_done = 1'b1;
  endtask

  // One clock: predict from pre-edge inputs, advance, then compare post-edge outputs.
  task automatic step();
    logic        hs, cap, was_last, rel_prev;
    logic [63:0] snap;
    hs          = out_valid && out_ready;
    cap         = done && !m_prev_done && (exp_q.size() == 0) && !rel_exp && (cool == 0);
    snap        = c_flat;
    rel_prev    = rel_exp;
    m_prev_done = done;
    @(posedge clock);
    #1;
    was_last = 1'b0;
    if (hs && exp_q.size() > 0) begin
      was_last = (exp_q[0].idx == 2'd3);
      void'(exp_q.pop_front());
      hs_count++;
    end
    rel_exp = was_last;
    cool    = rel_prev ? 1 : ((cool > 0) ? cool - 1 : 0);
    if (cap) begin
      for (int i = 0; i < 4; i++) begin
        exp_q.push_back('{snap[i*16 +: 16], 2'(i)});
      end
    end
    if (!reset) model_clear();
    if (release_pulse) rel_count++;
    chk("valid", out_valid, exp_q.size() != 0);
    chk("release", release_pulse, rel_exp);
    if (out_valid && exp_q.size() != 0) begin
      chk("data", out_data, exp_q[0].data);
      chk("index", out_index, exp_q[0].idx);
      chk("last", out_last, exp_q[0].idx == 2'd3);
    end
  endtask

  initial begin
    logic [15:0] held;
    int          hs0, rel0;
    logic [6:0]  rdy_pat;

    n_checks  = 0;
    n_errors  = 0;
    hs_count  = 0;
    rel_count = 0;
    model_clear();
    reset     = 1'b0;
    done      = 1'b0;
    out_ready = 1'b0;
    c_flat    = '0;
    step();
    step();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_release", release_pulse, 1'b0);
    chk("rst_data", out_data, 16'h0);
    chk("rst_index", out_index, 2'd0);
    reset = 1'b1;
    step();
    step();

    // Basic drain with out_ready held high
    c_flat    = {16'd4, 16'd3, 16'd2, 16'd1};
    out_ready = 1'b1;
    done      = 1'b1;
    step();
    done = 1'b0;
    chk("t1_latency", out_valid, 1'b1);
    chk("t1_d0", out_data, 16'd1);
    step();
    chk("t1_d1", out_data, 16'd2);
    step();
    chk("t1_d2", out_data, 16'd3);
    step();
    chk("t1_d3", out_data, 16'd4);
    chk("t1_idx3", out_index, 2'd3);
    chk("t1_last", out_last, 1'b1);
    step();
    chk("t1_release", release_pulse, 1'b1);
    chk("t1_busy_rel", busy, 1'b1);
    step();
    chk("t1_release_once", release_pulse, 1'b0);
    chk("t1_busy_wait", busy, 1'b1);
    step();
    chk("t1_busy_idle", busy, 1'b0);
    step();

    // Backpressure pattern 1,0,0,1,0,1,1
    done = 1'b1;
    step();
    done    = 1'b0;
    hs0     = hs_count;
    rdy_pat = 7'b1101001;
    for (int i = 0; i < 7; i++) begin
      out_ready = rdy_pat[i];
      held      = out_data;
      step();
      if (!rdy_pat[i]) chk("t2_stall_hold", out_data, held);
    end
    chk("t2_handshakes", hs_count - hs0, 4);
    chk("t2_release", release_pulse, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Source changes after capture must not leak through
    done = 1'b1;
    step();
    done   = 1'b0;
    c_flat = {4{16'hFFFF}};
    chk("t3_d0", out_data, 16'd1);
    step();
    chk("t3_d1", out_data, 16'd2);
    step();
    chk("t3_d2", out_data, 16'd3);
    step();
    chk("t3_d3", out_data, 16'd4);
    for (int i = 0; i < 3; i++) step();

    // done held for 20 cycles gives one drain; a fresh edge gives a second
    c_flat = {16'hD3, 16'hC2, 16'hB1, 16'hA0};
    rel0   = rel_count;
    done   = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("t4_one_release", rel_count - rel0, 1);
    chk("t4_no_redrain", out_valid, 1'b0);
    done = 1'b0;
    step();
    step();
    done = 1'b1;
    step();
    chk("t4_second_drain", out_valid, 1'b1);
    chk("t4_second_d0", out_data, 16'hA0);
    for (int i = 0; i < 8; i++) step();
    chk("t4_two_releases", rel_count - rel0, 2);
    done = 1'b0;
    step();
    step();

    // Reset mid-transfer, done high across reset release
    c_flat = {16'd4, 16'd3, 16'd2, 16'd1};
    done   = 1'b1;
    step();
    step();
    step();
    chk("t5_pre_idx", out_index, 2'd2);
    reset = 1'b0;
    #1;
    model_clear();
    chk("t5_rst_valid", out_valid, 1'b0);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_release", release_pulse, 1'b0);
    chk("t5_rst_index", out_index, 2'd0);
    step();
    step();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("t5_no_drain_busy", busy, 1'b0);
    done = 1'b0;
    step();
    done = 1'b1;
    step();
    chk("t5_rearm", out_valid, 1'b1);
    chk("t5_rearm_d0", out_data, 16'd1);

    // done falls during SEND
    step();
    step();
    done = 1'b0;
    step();
    step();
    chk("t6_release", release_pulse, 1'b1);
    step();
    chk("t6_wait_busy", busy, 1'b1);
    step();
    chk("t6_idle", busy, 1'b0);
    step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      c_flat    = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) done = ~done;
      step();
    end
    done      = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) step();
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
